// File: rtl/axis_matrix_stream_ctrl.sv
// AXI-Stream front/back end for the matrix multiply coprocessor.
// Accepts an M*N word A matrix followed by an N word B vector on the slave
// stream and writes them into A_RAM/B_RAM. It then runs matrix_multiply via a
// Start/Done handshake and streams the M result words from RES_RAM out on the
// master stream, with TLAST on the final word.

module axis_matrix_stream_ctrl #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 3,
    parameter int RES_depth_bits = 6,
    parameter int M              = 64,
    parameter int N              = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [31:0]               S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    input  logic                      S_AXIS_TLAST,
    output logic                      S_AXIS_TREADY,

    output logic [31:0]               M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    output logic                      M_AXIS_TLAST,
    input  logic                      M_AXIS_TREADY,

    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,

    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,

    output logic                      Start,
    input  logic                      Done,

    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out
);

    // Input word counter covers the whole frame: M*N A-words then N B-words.
    localparam int K_W = $clog2(M * N + N + 1);
    localparam logic [K_W-1:0] K_MN   = K_W'(M * N);
    localparam logic [K_W-1:0] K_LAST = K_W'(M * N + N - 1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);

    localparam logic [RES_depth_bits-1:0] R_LAST = RES_depth_bits'(M - 1);
    localparam logic [RES_depth_bits-1:0] R_ONE  = RES_depth_bits'(1);

    typedef enum logic [2:0] {
        ST_RECEIVE  = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_COMPUTE  = 3'd2,
        ST_OUT_RD   = 3'd3,
        ST_OUT_LAT  = 3'd4,
        ST_OUT_SEND = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [RES_depth_bits-1:0] r_q, r_d;

    logic                      a_we_q, a_we_d;
    logic [A_depth_bits-1:0]   a_addr_q, a_addr_d;
    logic [width-1:0]          a_data_q, a_data_d;
    logic                      b_we_q, b_we_d;
    logic [B_depth_bits-1:0]   b_addr_q, b_addr_d;
    logic [width-1:0]          b_data_q, b_data_d;

    logic                      start_q, start_d;
    logic                      rd_en_q, rd_en_d;
    logic [RES_depth_bits-1:0] rd_addr_q, rd_addr_d;

    logic [31:0]               tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;

    logic                      s_ready_s;
    logic                      s_hs_s;
    logic                      m_hs_s;

    // The frame length is fixed by the word count, so TLAST and the unused
    // upper data bits carry no information for this block.
    logic                      unused_s;
    assign unused_s = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:width]};

    // Slave ready is a pure function of the state, held low while in reset.
    always_comb begin
        s_ready_s = (state_q == ST_RECEIVE) && !reset;
    end

    assign S_AXIS_TREADY = s_ready_s;
    assign s_hs_s        = s_ready_s && S_AXIS_TVALID;
    assign m_hs_s        = tvalid_q && M_AXIS_TREADY;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        r_d       = r_q;
        a_we_d    = 1'b0;
        a_addr_d  = a_addr_q;
        a_data_d  = a_data_q;
        b_we_d    = 1'b0;
        b_addr_d  = b_addr_q;
        b_data_d  = b_data_q;
        start_d   = start_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;

        case (state_q)
            ST_RECEIVE: begin
                if (s_hs_s) begin
                    if (k_q < K_MN) begin
                        a_we_d   = 1'b1;
                        a_addr_d = A_depth_bits'(k_q);
                        a_data_d = S_AXIS_TDATA[width-1:0];
                    end else begin
                        b_we_d   = 1'b1;
                        b_addr_d = B_depth_bits'(k_q - K_MN);
                        b_data_d = S_AXIS_TDATA[width-1:0];
                    end
                    // k stops at the last index; it is cleared on re-entry.
                    if (k_q == K_LAST) begin
                        state_d = ST_FLUSH;
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end else begin
                    state_d = ST_RECEIVE;
                end
            end

            ST_FLUSH: begin
                // The final B write is being presented to the RAM this cycle.
                state_d = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                // Done only counts once Start has actually been driven.
                if (start_q && Done) begin
                    start_d   = 1'b0;
                    r_d       = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = ST_OUT_RD;
                end else begin
                    start_d = 1'b1;
                end
            end

            ST_OUT_RD: begin
                state_d = ST_OUT_LAT;
            end

            ST_OUT_LAT: begin
                tdata_d  = 32'(RES_read_data_out);
                tvalid_d = 1'b1;
                tlast_d  = (r_q == R_LAST);
                state_d  = ST_OUT_SEND;
            end

            ST_OUT_SEND: begin
                if (m_hs_s) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (r_q == R_LAST) begin
                        k_d     = '0;
                        state_d = ST_RECEIVE;
                    end else begin
                        r_d       = r_q + R_ONE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = r_q + R_ONE;
                        state_d   = ST_OUT_RD;
                    end
                end else begin
                    state_d = ST_OUT_SEND;
                end
            end

            default: begin
                k_d      = '0;
                start_d  = 1'b0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = ST_RECEIVE;
            end
        endcase
    end

    // State, counters and all registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RECEIVE;
            k_q       <= '0;
            r_q       <= '0;
            a_we_q    <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            b_we_q    <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            start_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tdata_q   <= 32'h0000_0000;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            r_q       <= r_d;
            a_we_q    <= a_we_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_we_q    <= b_we_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
            start_q   <= start_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    assign A_write_en       = a_we_q;
    assign A_write_address  = a_addr_q;
    assign A_write_data_in  = a_data_q;
    assign B_write_en       = b_we_q;
    assign B_write_address  = b_addr_q;
    assign B_write_data_in  = b_data_q;
    assign Start            = start_q;
    assign RES_read_en      = rd_en_q;
    assign RES_read_address = rd_addr_q;
    assign M_AXIS_TDATA     = tdata_q;
    assign M_AXIS_TVALID    = tvalid_q;
    assign M_AXIS_TLAST     = tlast_q;

    axis_matrix_stream_ctrl_chk u_chk (
        .clk     (clk),
        .reset   (reset),
        .a_we    (a_we_q),
        .b_we    (b_we_q),
        .s_ready (s_ready_s),
        .m_valid (tvalid_q),
        .start   (start_q),
        .rd_en   (rd_en_q)
    );

endmodule

// Structural invariants of the controller's outputs.
module axis_matrix_stream_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic a_we,
    input logic b_we,
    input logic s_ready,
    input logic m_valid,
    input logic start,
    input logic rd_en
);

    // Each accepted word lands in exactly one RAM.
    a_one_ram: assert property (@(posedge clk) disable iff (reset) !(a_we && b_we));

    // Input and output phases never overlap.
    a_phase: assert property (@(posedge clk) disable iff (reset) !(s_ready && m_valid));

    // Result readout only starts after Start has been withdrawn.
    a_start_rd: assert property (@(posedge clk) disable iff (reset) !(start && rd_en));

endmodule

// File: tb/tb_axis_matrix_stream_ctrl.sv
// Self-checking bench for axis_matrix_stream_ctrl: random input frames, a
// stub matrix_multiply computing from the captured RAM contents, and a
// reference built directly from the words sent.

module tb_axis_matrix_stream_ctrl;

    localparam int M     = 64;
    localparam int N     = 8;
    localparam int MN    = M * N;
    localparam int FRAME = MN + N;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic        A_write_en, B_write_en;
    logic [8:0]  A_write_address;
    logic [2:0]  B_write_address;
    logic [7:0]  A_write_data_in, B_write_data_in;
    logic        Start, Done;
    logic        RES_read_en;
    logic [5:0]  RES_read_address;
    logic [7:0]  RES_read_data_out;

    always #5 clk = ~clk;

    axis_matrix_stream_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .A_write_en        (A_write_en),
        .A_write_address   (A_write_address),
        .A_write_data_in   (A_write_data_in),
        .B_write_en        (B_write_en),
        .B_write_address   (B_write_address),
        .B_write_data_in   (B_write_data_in),
        .Start             (Start),
        .Done              (Done),
        .RES_read_en       (RES_read_en),
        .RES_read_address  (RES_read_address),
        .RES_read_data_out (RES_read_data_out)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] frame   [FRAME];
    logic [7:0] exp_res [M];
    logic [7:0] a_mem   [MN];
    logic [7:0] b_mem   [N];
    logic [7:0] res_mem [M];
    int         w_idx;
    int         res_mode;
    int         st_cnt;
    logic       done_stub, done_force;
    logic [7:0] res_rd;

    assign Done              = done_stub | done_force;
    assign RES_read_data_out = res_rd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stub matrix product over the captured RAM contents.
    function automatic logic [7:0] stub_dot(input int i);
        int acc = 0;
        for (int j = 0; j < N; j++) acc += int'(a_mem[i*N+j]) * int'(b_mem[j]);
        return 8'(acc);
    endfunction

    // Reference results straight from the sent words.
    task automatic model_expect();
        for (int i = 0; i < M; i++) begin
            int acc = 0;
            for (int j = 0; j < N; j++) acc += int'(frame[i*N+j]) * int'(frame[MN+j]);
            exp_res[i] = (res_mode == 0) ? 8'(i + 100) : 8'(acc);
        end
    endtask

    // Synchronous-read RES_RAM with one cycle latency.
    always @(posedge clk) begin
        if (RES_read_en) res_rd <= res_mem[RES_read_address];
    end

    // Stub matrix_multiply: raises Done ten cycles after Start and fills RES_RAM.
    always @(posedge clk) begin
        if (reset || !Start) begin
            st_cnt    <= 0;
            done_stub <= 1'b0;
        end else begin
            st_cnt <= st_cnt + 1;
            if (st_cnt == 9) begin
                done_stub <= 1'b1;
                for (int i = 0; i < M; i++)
                    res_mem[i] <= (res_mode == 0) ? 8'(i + 100) : stub_dot(i);
            end
        end
    end

    // Write-port monitor: each handshake must give exactly one write pulse next cycle.
    task automatic monitor_loop();
        logic hs_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_pend) begin
                if (w_idx >= FRAME) begin
                    check_eq("w_overrun", 32'(w_idx), 32'(FRAME - 1));
                end else if (w_idx < MN) begin
                    check_eq("a_we", 32'(A_write_en), 32'd1);
                    check_eq("a_addr", 32'(A_write_address), 32'(w_idx));
                    check_eq("a_data", 32'(A_write_data_in), 32'(frame[w_idx]));
                    check_eq("b_we_off", 32'(B_write_en), 32'd0);
                end else begin
                    check_eq("b_we", 32'(B_write_en), 32'd1);
                    check_eq("b_addr", 32'(B_write_address), 32'(w_idx - MN));
                    check_eq("b_data", 32'(B_write_data_in), 32'(frame[w_idx]));
                    check_eq("a_we_off", 32'(A_write_en), 32'd0);
                end
                w_idx++;
            end else if (A_write_en || B_write_en) begin
                check_eq("stray_we", {30'd0, A_write_en, B_write_en}, 32'd0);
            end
            if (A_write_en) a_mem[A_write_address] = A_write_data_in;
            if (B_write_en) b_mem[B_write_address] = B_write_data_in;
            hs_pend = S_AXIS_TVALID && S_AXIS_TREADY;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 three idle cycles between words, 2 random gaps.
    task automatic send_frame(input int nwords, input int gap_mode, input int rand_data);
        int n;
        for (int i = 0; i < FRAME; i++) frame[i] = (rand_data != 0) ? 8'($urandom) : 8'(i);
        w_idx = 0;
        for (int i = 0; i < nwords; i++) begin
            if (gap_mode == 1 && i > 0) begin
                S_AXIS_TVALID = 1'b0;
                repeat (3) tick();
            end else if (gap_mode == 2) begin
                n = int'($urandom_range(0, 2));
                if (n > 0) begin
                    S_AXIS_TVALID = 1'b0;
                    repeat (n) tick();
                end
            end
            S_AXIS_TDATA  = {24'($urandom), frame[i]};
            S_AXIS_TLAST  = (i == 10);
            S_AXIS_TVALID = 1'b1;
            n = 0;
            while (!S_AXIS_TREADY && n < 20) begin
                tick();
                n++;
            end
            if (!S_AXIS_TREADY) begin
                check_eq("s_ready_timeout", 32'(S_AXIS_TREADY), 32'd1);
                break;
            end
            tick();
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        done_force    = 1'b0;
        if (nwords == FRAME) begin
            check_eq("tready_drop", 32'(S_AXIS_TREADY), 32'd0);
            check_eq("start_e0", 32'(Start), 32'd0);
            tick();
            check_eq("start_e1", 32'(Start), 32'd0);
            tick();
            check_eq("start_e2", 32'(Start), 32'd1);
            check_eq("write_count", 32'(w_idx), 32'(FRAME));
        end
    endtask

    task automatic wait_compute();
        int n = 0;
        while (Start && n < 100) begin
            tick();
            n++;
        end
        check_eq("start_hold", 32'(n), 32'd11);
        check_eq("rd_en_first", 32'(RES_read_en), 32'd1);
        check_eq("rd_addr_first", 32'(RES_read_address), 32'd0);
        check_eq("tvalid_early", 32'(M_AXIS_TVALID), 32'd0);
    endtask

    task automatic recv_frame(input int stall_word, input int stall_len, input int rand_rdy);
        int n, d, words;
        words = 0;
        for (int i = 0; i < M; i++) begin
            n = 0;
            while (!M_AXIS_TVALID && n < 10) begin
                tick();
                n++;
            end
            check_eq("out_latency", 32'(n), 32'd2);
            if (!M_AXIS_TVALID) break;
            check_eq("tdata", M_AXIS_TDATA, 32'(exp_res[i]));
            check_eq("tlast", 32'(M_AXIS_TLAST), 32'(i == M - 1));
            d = (i == stall_word) ? stall_len : ((rand_rdy != 0) ? int'($urandom_range(0, 2)) : 0);
            repeat (d) begin
                tick();
                check_eq("hold_tdata", M_AXIS_TDATA, 32'(exp_res[i]));
                check_eq("hold_tvalid", 32'(M_AXIS_TVALID), 32'd1);
                check_eq("hold_tlast", 32'(M_AXIS_TLAST), 32'(i == M - 1));
            end
            M_AXIS_TREADY = 1'b1;
            tick();
            M_AXIS_TREADY = 1'b0;
            words++;
            check_eq("tvalid_drop", 32'(M_AXIS_TVALID), 32'd0);
            if (i < M - 1) begin
                check_eq("rd_en", 32'(RES_read_en), 32'd1);
                check_eq("rd_addr", 32'(RES_read_address), 32'(i + 1));
            end
        end
        check_eq("word_count", 32'(words), 32'(M));
        check_eq("back_to_rx", 32'(S_AXIS_TREADY), 32'd1);
        check_eq("tlast_clear", 32'(M_AXIS_TLAST), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tready"}, 32'(S_AXIS_TREADY), 32'd0);
        check_eq({tag, "_tvalid"}, 32'(M_AXIS_TVALID), 32'd0);
        check_eq({tag, "_tdata"}, M_AXIS_TDATA, 32'd0);
        check_eq({tag, "_tlast"}, 32'(M_AXIS_TLAST), 32'd0);
        check_eq({tag, "_start"}, 32'(Start), 32'd0);
        check_eq({tag, "_rd_en"}, 32'(RES_read_en), 32'd0);
        check_eq({tag, "_a_we"}, 32'(A_write_en), 32'd0);
        check_eq({tag, "_a_addr"}, 32'(A_write_address), 32'd0);
        check_eq({tag, "_b_we"}, 32'(B_write_en), 32'd0);
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        S_AXIS_TDATA  = 32'd0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        done_force    = 1'b0;
        res_mode      = 0;
        w_idx         = 0;
        fork
            monitor_loop();
        join_none

        // Reset values.
        repeat (3) tick();
        check_outputs_zero("rst");
        reset = 1'b0;
        #1;
        check_eq("rst_tready_after", 32'(S_AXIS_TREADY), 32'd1);

        // Back-to-back k mod 256 frame, preloaded results, stall on word 3.
        res_mode = 0;
        send_frame(FRAME, 0, 0);
        model_expect();
        wait_compute();
        recv_frame(3, 5, 0);

        // Random data with 3-cycle gaps and Done held high during input.
        res_mode   = 1;
        done_force = 1'b1;
        send_frame(FRAME, 1, 1);
        model_expect();
        wait_compute();
        recv_frame(-1, 0, 1);

        // Partial frame, reset, then a full new frame.
        send_frame(100, 2, 1);
        tick();
        tick();
        check_eq("partial_count", 32'(w_idx), 32'd100);
        reset = 1'b1;
        tick();
        tick();
        check_outputs_zero("rst_rx");
        reset = 1'b0;
        #1;
        check_eq("rst_rx_tready", 32'(S_AXIS_TREADY), 32'd1);
        send_frame(FRAME, 2, 1);
        model_expect();
        wait_compute();
        recv_frame(-1, 0, 1);

        // Reset while a result word is being offered.
        send_frame(FRAME, 0, 1);
        model_expect();
        wait_compute();
        n = 0;
        while (!M_AXIS_TVALID && n < 10) begin
            tick();
            n++;
        end
        check_eq("pre_rst_tvalid", 32'(M_AXIS_TVALID), 32'd1);
        reset = 1'b1;
        tick();
        check_outputs_zero("rst_tx");
        reset = 1'b0;
        #1;
        check_eq("rst_tx_tready", 32'(S_AXIS_TREADY), 32'd1);
        n = 0;
        repeat (20) begin
            tick();
            if (Start) n++;
        end
        check_eq("no_start_after_rst", 32'(n), 32'd0);

        // Final random frame.
        send_frame(FRAME, 2, 1);
        model_expect();
        wait_compute();
        recv_frame(10, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
